stream_unpack: RTL

STREAM_UNPACK -- requirements
Module: stream_unpack

---
 rtl/stream_pkg.sv | 15 +
 rtl/stream_unpack.sv | 101 ++++++++++
 2 files changed

// File: rtl/stream_pkg.sv
// Shared constants and helpers for the stream width converters.
package stream_pkg;

    localparam int BEAT_ORDER_LE = 0;
    localparam int BEAT_ORDER_BE = 1;

    function automatic int count_width(input int ratio);
        return $clog2(ratio) + 1;
    endfunction

    // Beat-count type for the common 4:1 configuration; other ratios size via count_width().
    localparam int DEFAULT_RATIO = 4;
    typedef logic [count_width(DEFAULT_RATIO)-1:0] beat_count_t;

endpackage

// File: rtl/stream_unpack.sv
// Splits wide words into NARROW_WIDTH beats, one beat per cycle, with valid/ready on both sides.
// Define STREAM_UNPACK_COUNT_EN to honour in_count for partial words; otherwise every word emits RATIO beats.
module stream_unpack
    import stream_pkg::*;
#(
    parameter int NARROW_WIDTH = 8,
    parameter int RATIO        = 4,
    parameter int BIG_ENDIAN   = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NARROW_WIDTH*RATIO-1:0]     in_data,
    input  logic [count_width(RATIO)-1:0]     in_count,
    input  logic                              in_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NARROW_WIDTH-1:0]           out_data,
    output logic                              out_last
);

    localparam int WORD_W = NARROW_WIDTH * RATIO;
    localparam int IDX_W  = $clog2(RATIO);
    localparam int CNT_W  = count_width(RATIO);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(RATIO - 1);

    if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
        $fatal(1, "stream_unpack: RATIO must be a power of 2 and at least 2");
    end
    if (NARROW_WIDTH < 1) begin : g_bad_width
        $fatal(1, "stream_unpack: NARROW_WIDTH must be at least 1");
    end

    logic [WORD_W-1:0]       data_q;
    logic [IDX_W-1:0]        idx_q;
    logic [CNT_W-1:0]        rem_q;
    logic                    last_q;
    logic                    full_q;

    logic [NARROW_WIDTH-1:0] beats [RATIO];
    logic [IDX_W-1:0]        sel;
    logic [CNT_W-1:0]        eff_count;
    logic                    final_beat;
    logic                    out_fire;
    logic                    in_fire;

    for (genvar k = 0; k < RATIO; k++) begin : g_beats
        assign beats[k] = data_q[k*NARROW_WIDTH +: NARROW_WIDTH];
    end

    assign sel        = (BIG_ENDIAN == BEAT_ORDER_BE) ? (LAST_IDX - idx_q) : idx_q;
    assign out_valid  = full_q && !rst;
    assign out_data   = beats[sel];
    assign final_beat = (rem_q == CNT_W'(1));
    assign out_last   = out_valid && last_q && final_beat;
    assign out_fire   = out_valid && out_ready;

    // A new word may enter in the same cycle the held word's final beat leaves, so words stream without a bubble.
    assign in_ready   = !rst && (!full_q || (out_fire && final_beat));
    assign in_fire    = in_valid && in_ready;

`ifdef STREAM_UNPACK_COUNT_EN
    always_comb begin
        eff_count = in_count;
        if (in_count == '0 || in_count > FULL_COUNT) begin
            eff_count = FULL_COUNT;
        end
    end
`else
    logic unused_count;
    assign unused_count = ^in_count;
    assign eff_count    = FULL_COUNT;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            idx_q  <= '0;
            rem_q  <= '0;
            last_q <= 1'b0;
        end else if (in_fire) begin
            data_q <= in_data;
            full_q <= 1'b1;
            idx_q  <= '0;
            rem_q  <= eff_count;
            last_q <= in_last;
        end else if (out_fire) begin
            if (final_beat) begin
                full_q <= 1'b0;
                idx_q  <= '0;
                rem_q  <= '0;
            end else begin
                idx_q  <= idx_q + IDX_W'(1);
                rem_q  <= rem_q - CNT_W'(1);
            end
        end
    end

endmodule
